// File: rtl/skeeball_score_bcd.sv
// rtl/skeeball_score_bcd.sv - skee-ball game controller with packed-BCD score and high score
// Score is kept in units of 10 points; hits add a BCD increment that saturates at all nines.
module skeeball_score_bcd #(
  parameter int DIGITS = 3,
  parameter int BALLS  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hit_valid,
  input  logic [2:0]            hit_code,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high_score,
  output logic [7:0]            balls_left,
  output logic                  playing,
  output logic                  game_over,
  output logic                  new_high
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t              state, state_nx;
  logic [4*DIGITS-1:0] score_nx, high_nx, inc_bcd, sum;
  logic [7:0]          balls_nx;
  logic                go_nx, nh_nx;
  logic                carry;
  logic [4:0]          dsum;

  // The 100-point hole is a carry into the tens digit; code 7 consumes a ball for nothing.
  always_comb begin
    inc_bcd = '0;
    case (hit_code)
      3'd6:    inc_bcd[7:4] = 4'd1;
      3'd7:    inc_bcd      = '0;
      default: inc_bcd[3:0] = {1'b0, hit_code};
    endcase
  end

  always_comb begin
    carry = 1'b0;
    dsum  = '0;
    sum   = '0;
    for (int d = 0; d < DIGITS; d++) begin
      dsum = {1'b0, score[4*d +: 4]} + {1'b0, inc_bcd[4*d +: 4]} + {4'b0, carry};
      if (dsum > 5'd9) begin
        dsum  = dsum - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*d +: 4] = dsum[3:0];
    end
    if (carry) sum = ALL_NINES;
  end

  always_comb begin
    state_nx = state;
    score_nx = score;
    high_nx  = high_score;
    balls_nx = balls_left;
    go_nx    = 1'b0;
    nh_nx    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = PLAY;
          score_nx = '0;
          balls_nx = 8'(BALLS);
        end
      end
      PLAY: begin
        if (hit_valid) begin
          score_nx = sum;
          balls_nx = balls_left - 8'd1;
          if (balls_left == 8'd1) begin
            state_nx = DONE;
            go_nx    = 1'b1;
            // Valid packed BCD orders the same as its unsigned binary image.
            if (sum > high_score) begin
              high_nx = sum;
              nh_nx   = 1'b1;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      score      <= '0;
      high_score <= '0;
      balls_left <= '0;
      game_over  <= 1'b0;
      new_high   <= 1'b0;
    end else begin
      state      <= state_nx;
      score      <= score_nx;
      high_score <= high_nx;
      balls_left <= balls_nx;
      game_over  <= go_nx;
      new_high   <= nh_nx;
    end
  end

  assign playing = (state == PLAY);

endmodule

// File: tb/tb_skeeball_score_bcd.sv
// tb/tb_skeeball_score_bcd.sv - randomized bench for skeeball_score_bcd against a decimal game model
// Three instances share stimulus: BALLS=9, BALLS=2 and BALLS=255 (to reach saturation).
module tb_skeeball_score_bcd;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hit_valid = 1'b0;
  logic [2:0] hit_code = 3'd0;

  logic [11:0] sc [N];
  logic [11:0] hs [N];
  logic [7:0]  bl [N];
  logic        pl [N];
  logic        go [N];
  logic        nh [N];

  int cfg [N] = '{9, 2, 255};
  int m_sc [N];
  int m_hs [N];
  int m_bl [N];
  bit m_pl [N];
  bit m_go [N];
  bit m_nh [N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  skeeball_score_bcd #(.DIGITS(3), .BALLS(9)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .hit_valid(hit_valid), .hit_code(hit_code),
    .score(sc[0]), .high_score(hs[0]), .balls_left(bl[0]), .playing(pl[0]),
    .game_over(go[0]), .new_high(nh[0]));

  skeeball_score_bcd #(.DIGITS(3), .BALLS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .hit_valid(hit_valid), .hit_code(hit_code),
    .score(sc[1]), .high_score(hs[1]), .balls_left(bl[1]), .playing(pl[1]),
    .game_over(go[1]), .new_high(nh[1]));

  skeeball_score_bcd #(.DIGITS(3), .BALLS(255)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .hit_valid(hit_valid), .hit_code(hit_code),
    .score(sc[2]), .high_score(hs[2]), .balls_left(bl[2]), .playing(pl[2]),
    .game_over(go[2]), .new_high(nh[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int points(input logic [2:0] c);
    if (c <= 3'd5) return int'(c);
    if (c == 3'd6) return 10;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sc[i] = 0; m_hs[i] = 0; m_bl[i] = 0;
      m_pl[i] = 0; m_go[i] = 0; m_nh[i] = 0;
    end
  endtask

  task automatic model_edge(input bit s, input bit hv, input logic [2:0] c);
    for (int i = 0; i < N; i++) begin
      m_go[i] = 0;
      m_nh[i] = 0;
      if (!m_pl[i]) begin
        if (s) begin
          m_pl[i] = 1; m_sc[i] = 0; m_bl[i] = cfg[i];
        end
      end else if (hv) begin
        m_sc[i] = (m_sc[i] + points(c) > 999) ? 999 : m_sc[i] + points(c);
        m_bl[i]--;
        if (m_bl[i] == 0) begin
          m_pl[i] = 0;
          m_go[i] = 1;
          if (m_sc[i] > m_hs[i]) begin
            m_hs[i] = m_sc[i];
            m_nh[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_u%0d_score", ph, i), 32'(sc[i]), 32'(bcd(m_sc[i])));
      check($sformatf("%s_u%0d_high", ph, i), 32'(hs[i]), 32'(bcd(m_hs[i])));
      check($sformatf("%s_u%0d_balls", ph, i), 32'(bl[i]), 32'(m_bl[i]));
      check($sformatf("%s_u%0d_playing", ph, i), 32'(pl[i]), 32'(m_pl[i]));
      check($sformatf("%s_u%0d_game_over", ph, i), 32'(go[i]), 32'(m_go[i]));
      check($sformatf("%s_u%0d_new_high", ph, i), 32'(nh[i]), 32'(m_nh[i]));
    end
  endtask

  task automatic cyc(input bit s, input bit hv, input logic [2:0] c);
    start = s; hit_valid = hv; hit_code = c;
    @(posedge clk);
    model_edge(s, hv, c);
    #1;
    check_all("cyc");
    start = 0; hit_valid = 0;
  endtask

  task automatic hit(input logic [2:0] c);
    cyc(1'b0, 1'b1, c);
  endtask

  // Called just after an edge so the pulse sits entirely between edges.
  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check_all("rst");
    #1;
    rst_n = 1;
  endtask

  initial begin
    #1;
    model_reset();
    check_all("por");
    #3;
    rst_n = 1;
    cyc(0, 0, 0);

    cyc(1, 0, 0);
    hit(6); hit(5); hit(4);
    check("r33_score", 32'(sc[0]), 32'h019);
    check("r33_balls", 32'(bl[0]), 32'd6);
    check("r33_playing", 32'(pl[0]), 32'd1);

    do_reset();
    cyc(1, 0, 0);
    hit(6); hit(1);
    check("r35_score", 32'(sc[1]), 32'h011);
    check("r35_balls", 32'(bl[1]), 32'd0);
    check("r35_game_over", 32'(go[1]), 32'd1);
    check("r35_new_high", 32'(nh[1]), 32'd1);
    check("r35_high", 32'(hs[1]), 32'h011);
    cyc(0, 0, 0);
    check("r35_pulse_end", 32'(go[1]), 32'd0);

    cyc(1, 0, 0);
    hit(6); hit(1);
    check("r36_tie_go", 32'(go[1]), 32'd1);
    check("r36_tie_nh", 32'(nh[1]), 32'd0);
    check("r36_tie_high", 32'(hs[1]), 32'h011);
    cyc(1, 0, 0);
    hit(6); hit(2);
    check("r36_high", 32'(hs[1]), 32'h012);

    hit(3);
    check("r37_done_hit", 32'(sc[1]), 32'h012);
    cyc(1, 0, 0);
    do_reset();
    cyc(1, 1, 6);
    check("r37_start_hit_score", 32'(sc[0]), 32'h000);
    check("r37_start_hit_balls", 32'(bl[0]), 32'd9);

    hit(6); hit(6); hit(6); hit(6);
    check("r38_score_pre", 32'(sc[0]), 32'h040);
    @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    check("r38_score", 32'(sc[0]), 32'h000);
    check("r38_high", 32'(hs[0]), 32'h000);
    check("r38_go", 32'(go[0]), 32'd0);
    check_all("r38");
    #1;
    rst_n = 1;
    cyc(0, 0, 0);

    cyc(1, 0, 0);
    for (int k = 0; k < 9; k++) hit(6);
    hit(5);
    check("r34_095", 32'(sc[2]), 32'h095);
    hit(6);
    check("r34_carry", 32'(sc[2]), 32'h105);
    for (int k = 0; k < 88; k++) hit(6);
    hit(5); hit(4); hit(4);
    check("r34_998", 32'(sc[2]), 32'h998);
    hit(5);
    check("r34_sat", 32'(sc[2]), 32'h999);
    hit(6);
    check("r34_sat_hold", 32'(sc[2]), 32'h999);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
